// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM encoding, default width and
// the divide-by-zero quotient pattern.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_W = 4;

  // Sliced to the operand width by users; all ones reads as -1 in signed mode.
  localparam logic [63:0] DZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: W+1-bit trial subtract of the divisor from the
// shifted partial remainder, using add of the inverted divisor with carry-in 1.
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   rem_sh,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic         qbit
);

  logic [W:0] diff;

  assign diff = rem_sh + {1'b1, ~divisor} + {{W{1'b0}}, 1'b1};
  assign qbit = ~diff[W];
  // A kept remainder is always below the divisor, so W bits hold it.
  assign rem_nxt = qbit ? diff[W-1:0] : rem_sh[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_SIGNED_EN: two's-complement operands with a FIX sign cycle.
import arith_pkg::*;

module seq_divider #(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
`ifdef DIV_SIGNED_EN
  localparam logic [1:0] S_FIX  = FIX;
`endif

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  // Restored partial remainder; its W+1-th bit is always zero so only the
  // trial subtract in div_step carries the extra bit.
  logic [W-1:0]  rem_r;
  logic [W-1:0]  q_r, dvs_r, dvd_r;
  logic          dz_r;
  logic [W-1:0]  dvd_mag, dvs_mag;
  logic [W:0]    rem_sh;
  logic [W-1:0]  rem_nxt;
  logic          qbit;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign dvd_mag = dividend[W-1] ? -dividend : dividend;
  assign dvs_mag = divisor[W-1]  ? -divisor  : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  assign rem_sh = {rem_r, q_r[W-1]};

  div_step #(.W(W)) u_step (
    .rem_sh  (rem_sh),
    .divisor (dvs_r),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      dvd_r       <= '0;
      dz_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= CW'(W-1);
            rem_r       <= '0;
            q_r         <= dvd_mag;
            dvs_r       <= dvs_mag;
            dvd_r       <= dividend;
            dz_r        <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            neg_q       <= dividend[W-1] ^ divisor[W-1];
            neg_r       <= dividend[W-1];
`endif
          end
        end
        S_RUN: begin
          if (dz_r) begin
            // Zero divisor resolves in a single cycle with the raw dividend.
            quotient    <= DZ_QUOT[W-1:0];
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            rem_r <= rem_nxt;
            q_r   <= {q_r[W-2:0], qbit};
            if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
              state     <= S_FIX;
`else
              quotient  <= {q_r[W-2:0], qbit};
              remainder <= rem_nxt;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
`endif
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          // Truncate toward zero; remainder follows the dividend's sign.
          quotient  <= neg_q ? -q_r : q_r;
          remainder <= neg_r ? -rem_r : rem_r;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
